// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg
//  Purpose  : Shared widths, limits and time-bus helpers for the digital
//             clock (timekeeping, alarm and display stages).
//  Revision : 1.0 - initial release
// ============================================================================
package clock_pkg;

  localparam int HOUR_W   = 5;
  localparam int MIN_W    = 6;
  localparam int SEC_W    = 6;
  localparam int TIME_W   = HOUR_W + MIN_W;
  localparam int BCD_W    = 13;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MIN  = 59;
  localparam int MAX_SEC  = 59;

  // Hour field of the {hour,min} time bus
  function automatic logic [HOUR_W-1:0] get_hour(input logic [TIME_W-1:0] t);
    return t[TIME_W-1:MIN_W];
  endfunction

  // Minute field of the {hour,min} time bus
  function automatic logic [MIN_W-1:0] get_min(input logic [TIME_W-1:0] t);
    return t[MIN_W-1:0];
  endfunction

  // Build a time bus word from its fields
  function automatic logic [TIME_W-1:0] pack_time(input logic [HOUR_W-1:0] h,
                                                  input logic [MIN_W-1:0]  m);
    return {h, m};
  endfunction

  // Binary 0..59 to two BCD digits {tens[3:0], ones[3:0]}.
  // Tens is found by threshold compare, which stays shallow for this range.
  function automatic logic [7:0] bin_to_bcd(input logic [6:0] v);
    logic [2:0] t;
    logic [6:0] t10;
    logic [3:0] ones;
    if (v >= 7'd50)      t = 3'd5;
    else if (v >= 7'd40) t = 3'd4;
    else if (v >= 7'd30) t = 3'd3;
    else if (v >= 7'd20) t = 3'd2;
    else if (v >= 7'd10) t = 3'd1;
    else                 t = 3'd0;
    t10  = 7'({t, 3'b000}) + 7'({t, 1'b0});
    ones = 4'(v - t10);
    return {1'b0, t, ones};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_counter
//  Purpose  : Counter that wraps from MAX to 0, with synchronous load and a
//             combinational carry flagging the wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module mod_counter #(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             carry
);

  localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

  // A load always overrides counting, so it never produces a carry
  assign carry = inc && !load && (count == c_max);

  // Count register: reset, then load, then increment with wrap
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= carry ? '0 : count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : time_counter
//  Purpose  : Timekeeping core. Divides clk down to a 1 Hz tick and counts
//             seconds, minutes and hours (24 h), with user time load,
//             enable gating and one-cycle second/minute/day pulses.
//  Options  : TIME_BCD_EN - adds the time_bcd port fed by parallel BCD
//             digit counters that track time_out.
//  Revision : 1.0 - initial release
// ============================================================================
module time_counter
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              set_time,
  input  logic [TIME_W-1:0] time_set_in,
  output logic [TIME_W-1:0] time_out,
  output logic [SEC_W-1:0]  sec_out,
  output logic              sec_pulse,
  output logic              min_pulse,
  output logic              day_pulse,
  output logic              set_err
`ifdef TIME_BCD_EN
  ,
  output logic [BCD_W-1:0]  time_bcd
`endif
);

  localparam int                 c_presc_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [c_presc_w-1:0] c_presc_max = c_presc_w'(TICK_DIV - 1);

  logic [c_presc_w-1:0] r_presc;
  logic [HOUR_W-1:0]    w_hour;
  logic [MIN_W-1:0]     w_min;
  logic [HOUR_W-1:0]    w_set_hour;
  logic [MIN_W-1:0]     w_set_min;
  logic                 w_tick;
  logic                 w_set_valid;
  logic                 w_set_err;
  logic                 w_sec_inc;
  logic                 w_sec_carry;
  logic                 w_min_carry;
  logic                 w_hour_carry;

  assign w_set_hour  = get_hour(time_set_in);
  assign w_set_min   = get_min(time_set_in);
  assign w_set_valid = set_time && (w_set_hour <= HOUR_W'(MAX_HOUR))
                                && (w_set_min  <= MIN_W'(MAX_MIN));
  assign w_set_err   = set_time && !w_set_valid;
  assign w_tick      = en && (r_presc == c_presc_max);
  // A valid load swallows a coincident tick; a rejected one lets it through
  assign w_sec_inc   = w_tick && !w_set_valid;

  // Prescaler: restarts on a valid load, advances only while enabled
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_set_valid) begin
      r_presc <= '0;
    end else if (en) begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
    end
  end

  mod_counter #(.WIDTH(SEC_W), .MAX(MAX_SEC)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_inc),
    .load     (w_set_valid),
    .load_val ('0),
    .count    (sec_out),
    .carry    (w_sec_carry)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MAX_MIN)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_sec_carry),
    .load     (w_set_valid),
    .load_val (w_set_min),
    .count    (w_min),
    .carry    (w_min_carry)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(MAX_HOUR)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_min_carry),
    .load     (w_set_valid),
    .load_val (w_set_hour),
    .count    (w_hour),
    .carry    (w_hour_carry)
  );

  assign time_out = {w_hour, w_min};

  // Pulses are registered on the same edge that updates the counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      sec_pulse <= 1'b0;
      min_pulse <= 1'b0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      sec_pulse <= w_sec_inc;
      min_pulse <= w_sec_carry;
      day_pulse <= w_hour_carry;
      set_err   <= w_set_err;
    end
  end

`ifdef TIME_BCD_EN
  logic [1:0] r_h_tens;
  logic [3:0] r_h_ones;
  logic [2:0] r_m_tens;
  logic [3:0] r_m_ones;
  logic [7:0] w_m_load;
  logic [7:0] w_h_load;

  assign w_m_load = bin_to_bcd(7'(w_set_min));
  assign w_h_load = bin_to_bcd(7'(w_set_hour));

  // BCD digits step on the same carries as the binary counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_h_tens <= '0;
      r_h_ones <= '0;
      r_m_tens <= '0;
      r_m_ones <= '0;
    end else if (w_set_valid) begin
      r_h_tens <= 2'(w_h_load >> 4);
      r_h_ones <= 4'(w_h_load);
      r_m_tens <= 3'(w_m_load >> 4);
      r_m_ones <= 4'(w_m_load);
    end else begin
      if (w_sec_carry) begin
        if (r_m_ones == 4'd9) begin
          r_m_ones <= 4'd0;
          r_m_tens <= (r_m_tens == 3'd5) ? 3'd0 : r_m_tens + 3'd1;
        end else begin
          r_m_ones <= r_m_ones + 4'd1;
        end
      end
      if (w_min_carry) begin
        if (r_h_tens == 2'd2 && r_h_ones == 4'd3) begin
          r_h_tens <= 2'd0;
          r_h_ones <= 4'd0;
        end else if (r_h_ones == 4'd9) begin
          r_h_ones <= 4'd0;
          r_h_tens <= r_h_tens + 2'd1;
        end else begin
          r_h_ones <= r_h_ones + 4'd1;
        end
      end
    end
  end

  assign time_bcd = {r_h_tens, r_h_ones, r_m_tens, r_m_ones};
`endif

endmodule
`default_nettype wire

// File: tb/tb_time_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_counter
//  Purpose  : Directed self-checking bench for time_counter (TICK_DIV=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_time_counter;

  logic        clk;
  logic        rst;
  logic        en;
  logic        set_time;
  logic [10:0] time_set_in;
  logic [10:0] time_out;
  logic [5:0]  sec_out;
  logic        sec_pulse;
  logic        min_pulse;
  logic        day_pulse;
  logic        set_err;
`ifdef TIME_BCD_EN
  logic [12:0] time_bcd;
`endif

  int tests;
  int fails;

  time_counter #(.TICK_DIV(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .set_time    (set_time),
    .time_set_in (time_set_in),
    .time_out    (time_out),
    .sec_out     (sec_out),
    .sec_pulse   (sec_pulse),
    .min_pulse   (min_pulse),
    .day_pulse   (day_pulse),
    .set_err     (set_err)
`ifdef TIME_BCD_EN
    ,
    .time_bcd    (time_bcd)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load a valid time; afterwards prescaler=0 and seconds=0
  task automatic load_time(input logic [4:0] h, input logic [5:0] m);
    set_time    = 1'b1;
    time_set_in = {h, m};
    step();
    set_time    = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; set_time = 1'b0; time_set_in = '0;
    step(); step();
    rst = 1'b1;
    tests++;
    if ({time_out, sec_out, sec_pulse, min_pulse, day_pulse, set_err} !== 21'd0) begin
      fails++;
      $display("FAIL reset_state: time=%h sec=%0d pulses=%b%b%b err=%b, required all 0",
               time_out, sec_out, sec_pulse, min_pulse, day_pulse, set_err);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (sec_pulse !== (i == 4)) begin
        fails++;
        $display("FAIL first_tick cycle %0d: sec_pulse=%b, required %b", i, sec_pulse, (i == 4));
      end
    end
    tests++;
    if (sec_out !== 6'd1) begin
      fails++;
      $display("FAIL first_tick_sec: sec_out=%0d, required 1", sec_out);
    end
  endtask

  task automatic test_day_wrap();
    int npulse;
    int nday;
    npulse = 0; nday = 0;
    load_time(5'd23, 6'd59);
    tests++;
    if (time_out !== 11'b10111_111011 || sec_out !== 6'd0) begin
      fails++;
      $display("FAIL set_2359: time=%b sec=%0d, required 10111111011 sec 0", time_out, sec_out);
    end
    for (int i = 1; i <= 240; i++) begin
      step();
      if (sec_pulse) npulse++;
      if (day_pulse) nday++;
      if (i == 236) begin
        tests++;
        if (time_out !== 11'b10111_111011 || sec_out !== 6'd59 || min_pulse !== 1'b0) begin
          fails++;
          $display("FAIL pre_wrap: time=%b sec=%0d min_pulse=%b, required 23:59:59 no min_pulse",
                   time_out, sec_out, min_pulse);
        end
      end
    end
    tests++;
    if (time_out !== 11'd0 || sec_out !== 6'd0) begin
      fails++;
      $display("FAIL day_wrap_value: time=%b sec=%0d, required 0 0", time_out, sec_out);
    end
    tests++;
    if ({sec_pulse, min_pulse, day_pulse} !== 3'b111) begin
      fails++;
      $display("FAIL day_wrap_pulses: sec/min/day=%b, required 111", {sec_pulse, min_pulse, day_pulse});
    end
    tests++;
    if (npulse != 60 || nday != 1) begin
      fails++;
      $display("FAIL day_wrap_counts: sec_pulses=%0d day_pulses=%0d, required 60 1", npulse, nday);
    end
    step();
    tests++;
    if ({sec_pulse, min_pulse, day_pulse} !== 3'b000) begin
      fails++;
      $display("FAIL day_wrap_one_cycle: sec/min/day=%b, required 000", {sec_pulse, min_pulse, day_pulse});
    end
  endtask

  task automatic test_invalid_set();
    load_time(5'd10, 6'd20);             // presc 0
    step();                              // presc 1
    set_time = 1'b1; time_set_in = {5'd24, 6'd0};
    step();                              // presc 2, rejected
    set_time = 1'b0;
    tests++;
    if (set_err !== 1'b1 || time_out !== {5'd10, 6'd20} || sec_out !== 6'd0) begin
      fails++;
      $display("FAIL invalid_hour: err=%b time=%b sec=%0d, required 1 10:20 0", set_err, time_out, sec_out);
    end
    step();                              // presc 3
    tests++;
    if (set_err !== 1'b0 || sec_pulse !== 1'b0) begin
      fails++;
      $display("FAIL invalid_err_clear: err=%b sec_pulse=%b, required 0 0", set_err, sec_pulse);
    end
    step();                              // tick
    tests++;
    if (sec_pulse !== 1'b1 || sec_out !== 6'd1) begin
      fails++;
      $display("FAIL invalid_presc_kept: sec_pulse=%b sec=%0d, required 1 1", sec_pulse, sec_out);
    end
    step(); step(); step();              // presc 3
    set_time = 1'b1; time_set_in = {5'd5, 6'd60};
    step();                              // invalid set on tick: tick proceeds
    set_time = 1'b0;
    tests++;
    if (set_err !== 1'b1 || sec_pulse !== 1'b1 || sec_out !== 6'd2 || time_out !== {5'd10, 6'd20}) begin
      fails++;
      $display("FAIL invalid_on_tick: err=%b pulse=%b sec=%0d time=%b, required 1 1 2 10:20",
               set_err, sec_pulse, sec_out, time_out);
    end
  endtask

  task automatic test_enable();
    int bad;
    bad = 0;
    load_time(5'd1, 6'd0);
    step(); step();                      // presc 2
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (sec_pulse !== 1'b0 || sec_out !== 6'd0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL enable_freeze: %0d cycles moved while en=0, required 0", bad);
    end
    en = 1'b1;
    step();
    tests++;
    if (sec_pulse !== 1'b0) begin
      fails++;
      $display("FAIL enable_resume_early: sec_pulse=%b, required 0", sec_pulse);
    end
    step();
    tests++;
    if (sec_pulse !== 1'b1 || sec_out !== 6'd1) begin
      fails++;
      $display("FAIL enable_resume_tick: pulse=%b sec=%0d, required 1 1", sec_pulse, sec_out);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (sec_pulse !== (i == 4)) begin
        fails++;
        $display("FAIL enable_next_tick cycle %0d: sec_pulse=%b, required %b", i, sec_pulse, (i == 4));
      end
    end
  endtask

  task automatic test_set_on_tick();
    int bad;
    step(); step(); step();              // presc 3, next edge would tick
    set_time = 1'b1; time_set_in = {5'd7, 6'd30};
    step();
    set_time = 1'b0;
    tests++;
    if (time_out !== {5'd7, 6'd30} || sec_out !== 6'd0 || sec_pulse !== 1'b0) begin
      fails++;
      $display("FAIL set_on_tick: time=%b sec=%0d pulse=%b, required 07:30 0 0", time_out, sec_out, sec_pulse);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (sec_pulse !== (i == 4)) begin
        fails++;
        $display("FAIL set_on_tick_next cycle %0d: sec_pulse=%b, required %b", i, sec_pulse, (i == 4));
      end
    end
    // Holding set_time keeps the time frozen at the load value
    bad = 0;
    set_time = 1'b1; time_set_in = {5'd12, 6'd0};
    for (int i = 0; i < 8; i++) begin
      step();
      if (time_out !== {5'd12, 6'd0} || sec_out !== 6'd0 || sec_pulse !== 1'b0) bad++;
    end
    set_time = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL set_held: %0d cycles not frozen at 12:00:00, required 0", bad);
    end
  endtask

  task automatic test_reset_mid_second();
    step(); step();                      // presc 2
    rst = 1'b0;
    step();
    rst = 1'b1;
    tests++;
    if (time_out !== 11'd0 || sec_out !== 6'd0) begin
      fails++;
      $display("FAIL mid_reset_state: time=%b sec=%0d, required 0 0", time_out, sec_out);
    end
    for (int i = 1; i <= 4; i++) begin
      step();
      tests++;
      if (sec_pulse !== (i == 4)) begin
        fails++;
        $display("FAIL mid_reset_tick cycle %0d: sec_pulse=%b, required %b", i, sec_pulse, (i == 4));
      end
    end
  endtask

`ifdef TIME_BCD_EN
  task automatic test_bcd();
    load_time(5'd13, 6'd45);
    tests++;
    if (time_bcd !== {2'd1, 4'd3, 3'd4, 4'd5}) begin
      fails++;
      $display("FAIL bcd_load: time_bcd=%h, required %h", time_bcd, {2'd1, 4'd3, 3'd4, 4'd5});
    end
    for (int i = 0; i < 3600; i++) step();
    tests++;
    if (time_bcd !== {2'd1, 4'd4, 3'd0, 4'd0} || time_out !== {5'd14, 6'd0}) begin
      fails++;
      $display("FAIL bcd_count: time_bcd=%h time=%b, required %h 14:00",
               time_bcd, time_out, {2'd1, 4'd4, 3'd0, 4'd0});
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_day_wrap();
    test_invalid_set();
    test_enable();
    test_set_on_tick();
    test_reset_mid_second();
`ifdef TIME_BCD_EN
    test_bcd();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
